// File: rtl/test_pattern_generator.sv
// Video test-pattern source: streams one H_ACTIVE x V_ACTIVE frame per in_next_frame
// (gradient, colour bars, checkerboard or solid) over a valid/ready link with sof/eol.
module test_pattern_generator #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 480,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9,
    parameter int COLOR_BITS = 8,
    parameter int CHECK_LOG2 = 5
) (
    input  logic                    in_clk,
    input  logic                    in_reset_n,
    input  logic                    in_next_frame,
    input  logic [1:0]              in_mode,
    input  logic [3*COLOR_BITS-1:0] in_solid_color,
    output logic [3*COLOR_BITS-1:0] out_pixel_data,
    output logic                    out_pixel_valid,
    input  logic                    out_pixel_ready,
    output logic                    out_pixel_sof,
    output logic                    out_pixel_eol,
    output logic                    out_frame_done,
    output logic [15:0]             out_frame_count
);

    typedef enum logic {RUNNING, PAST_END} state_t;

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_ACTIVE - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [X_WIDTH-1:0]      r_x;
    logic [Y_WIDTH-1:0]      r_y;
    logic [1:0]              r_mode;
    logic [3*COLOR_BITS-1:0] r_color;
    logic                    r_latch_pend;
    logic [3*COLOR_BITS-1:0] r_data;
    logic                    r_valid;
    logic                    r_sof;
    logic                    r_eol;
    logic                    r_last;
    logic                    r_done;
    logic [15:0]             r_count;

    logic                    w_load;
    logic                    w_accept;
    logic                    w_frame_end;
    logic                    w_x_end;
    logic                    w_y_end;
    logic [1:0]              w_mode;
    logic [3*COLOR_BITS-1:0] w_color;
    logic [2:0]              w_bar;
    logic                    w_check;
    logic [3*COLOR_BITS-1:0] w_pixel;

    // Bar index = floor(8x/H) expressed as compares against ceil(k*H/8).
    function automatic logic [2:0] bar_index(input logic [X_WIDTH-1:0] x);
        logic [2:0] b;
        b = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (32'(x) >= (k * H_ACTIVE + 7) / 8)
                b = b + 3'd1;
        end
        return b;
    endfunction

    assign w_x_end  = (r_x == X_LAST);
    assign w_y_end  = (r_y == Y_LAST);
    assign w_accept = r_valid && out_pixel_ready;

    // The reset-time latch is taken on the first edge after release.
    assign w_mode  = r_latch_pend ? in_mode        : r_mode;
    assign w_color = r_latch_pend ? in_solid_color : r_color;
    assign w_bar   = bar_index(r_x);
    assign w_check = r_x[CHECK_LOG2] ^ r_y[CHECK_LOG2];

    always_comb begin
        w_pixel = '0;
        case (w_mode)
            2'd0: w_pixel = {COLOR_BITS'(r_x), COLOR_BITS'(r_y), COLOR_BITS'(r_count)};
            2'd1: w_pixel = {{COLOR_BITS{~w_bar[1]}}, {COLOR_BITS{~w_bar[2]}},
                             {COLOR_BITS{~w_bar[0]}}};
            2'd2: w_pixel = w_check ? '0 : '1;
            default: w_pixel = w_color;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_frame_end  = 1'b0;
        if (in_next_frame) begin
            w_state_next = RUNNING;
        end else begin
            w_frame_end = w_accept && r_last;
            if (r_state == RUNNING && (!r_valid || out_pixel_ready)) begin
                w_load = 1'b1;
                if (w_x_end && w_y_end)
                    w_state_next = PAST_END;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n)
            r_state <= RUNNING;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_mode       <= '0;
            r_color      <= '0;
            r_latch_pend <= 1'b1;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_sof        <= 1'b0;
            r_eol        <= 1'b0;
            r_last       <= 1'b0;
            r_done       <= 1'b0;
            r_count      <= '0;
        end else begin
            r_done <= w_frame_end;
            if (w_frame_end)
                r_count <= r_count + 16'd1;

            if (in_next_frame) begin
                r_valid      <= 1'b0;
                r_sof        <= 1'b0;
                r_eol        <= 1'b0;
                r_last       <= 1'b0;
                r_x          <= '0;
                r_y          <= '0;
                r_mode       <= in_mode;
                r_color      <= in_solid_color;
                r_latch_pend <= 1'b0;
            end else if (w_load) begin
                r_data  <= w_pixel;
                r_valid <= 1'b1;
                r_sof   <= (r_x == '0) && (r_y == '0);
                r_eol   <= w_x_end;
                r_last  <= w_x_end && w_y_end;
                if (w_x_end) begin
                    r_x <= '0;
                    r_y <= w_y_end ? '0 : r_y + Y_WIDTH'(1);
                end else begin
                    r_x <= r_x + X_WIDTH'(1);
                end
                if (r_latch_pend) begin
                    r_mode       <= in_mode;
                    r_color      <= in_solid_color;
                    r_latch_pend <= 1'b0;
                end
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_pixel_data  = r_data;
    assign out_pixel_valid = r_valid;
    assign out_pixel_sof   = r_sof;
    assign out_pixel_eol   = r_eol;
    assign out_frame_done  = r_done;
    assign out_frame_count = r_count;

endmodule

// File: tb/tb_test_pattern_generator.sv
// Directed bench for test_pattern_generator: an 8x4 instance for stream/frame behaviour
// and an 800x1 instance for colour-bar thresholds.
module tb_test_pattern_generator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        nf;
    logic [1:0]  mode;
    logic [23:0] color;
    logic        ready;

    logic [23:0] s_data;
    logic        s_valid, s_sof, s_eol, s_done;
    logic [15:0] s_count;
    logic [23:0] b_data;
    logic        b_valid, b_sof, b_eol, b_done;
    logic [15:0] b_count;

    always #5 clk = ~clk;

    test_pattern_generator #(
        .H_ACTIVE(8), .V_ACTIVE(4), .X_WIDTH(3), .Y_WIDTH(2),
        .COLOR_BITS(8), .CHECK_LOG2(1)
    ) dut (
        .in_clk(clk), .in_reset_n(rst_n), .in_next_frame(nf), .in_mode(mode),
        .in_solid_color(color), .out_pixel_data(s_data), .out_pixel_valid(s_valid),
        .out_pixel_ready(ready), .out_pixel_sof(s_sof), .out_pixel_eol(s_eol),
        .out_frame_done(s_done), .out_frame_count(s_count)
    );

    test_pattern_generator #(
        .H_ACTIVE(800), .V_ACTIVE(1), .X_WIDTH(10), .Y_WIDTH(9),
        .COLOR_BITS(8), .CHECK_LOG2(5)
    ) dut_bar (
        .in_clk(clk), .in_reset_n(rst_n), .in_next_frame(nf), .in_mode(mode),
        .in_solid_color(color), .out_pixel_data(b_data), .out_pixel_valid(b_valid),
        .out_pixel_ready(ready), .out_pixel_sof(b_sof), .out_pixel_eol(b_eol),
        .out_frame_done(b_done), .out_frame_count(b_count)
    );

    typedef struct {
        int          phase;
        int          idx;
        logic [23:0] data;
        logic        sof;
        logic        eol;
    } vec_t;

    typedef struct {
        int          x;
        logic [23:0] data;
    } bar_t;

    vec_t tbl[19];
    bar_t btbl[11];

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] cap_data[32];
    logic        cap_sof[32];
    logic        cap_eol[32];
    int          cap_n;
    int          done_cnt;
    logic [23:0] bar_cap[800];
    int          bar_n;

    logic        stalled;
    logic [23:0] held_data;
    logic        held_sof, held_eol;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic reset_cap();
        for (int i = 0; i < 32; i++) begin
            cap_data[i] = 'x;
            cap_sof[i]  = 1'bx;
            cap_eol[i]  = 1'bx;
        end
        cap_n    = 0;
        done_cnt = 0;
        bar_n    = 0;
    endtask

    // Runs a fixed number of cycles, recording accepted pixels and checking stall holds.
    task automatic collect(input int cycles, input bit rnd);
        stalled = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (stalled) begin
                chk("stall_valid", 32'(s_valid), 32'd1);
                chk("stall_data", 32'(s_data), 32'(held_data));
                chk("stall_sof_eol", {30'd0, s_sof, s_eol}, {30'd0, held_sof, held_eol});
            end
            if (s_done) done_cnt++;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_valid && ready) begin
                if (cap_n < 32) begin
                    cap_data[cap_n] = s_data;
                    cap_sof[cap_n]  = s_sof;
                    cap_eol[cap_n]  = s_eol;
                end
                cap_n++;
            end
            if (b_valid && ready) begin
                if (bar_n < 800) bar_cap[bar_n] = b_data;
                bar_n++;
            end
            stalled   = s_valid && !ready;
            held_data = s_data;
            held_sof  = s_sof;
            held_eol  = s_eol;
        end
    endtask

    task automatic pulse_next();
        @(negedge clk);
        nf = 1'b1;
        @(negedge clk);
        nf = 1'b0;
        chk("nf_valid_low", 32'(s_valid), 32'd0);
    endtask

    task automatic apply_table(input int ph);
        for (int i = 0; i < 19; i++) begin
            if (tbl[i].phase == ph) begin
                chk($sformatf("p%0d_pix%0d_data", ph, tbl[i].idx),
                    32'(cap_data[tbl[i].idx]), 32'(tbl[i].data));
                chk($sformatf("p%0d_pix%0d_sof_eol", ph, tbl[i].idx),
                    {30'd0, cap_sof[tbl[i].idx], cap_eol[tbl[i].idx]},
                    {30'd0, tbl[i].sof, tbl[i].eol});
            end
        end
    endtask

    logic [15:0] cnt0;
    bit          found;
    int          sof_cnt;

    initial begin
        // phase 1: gradient (f = 0); phase 2: checker, square 2; phase 3: bars at H=8
        tbl[0]  = '{1, 0,  24'h000000, 1'b1, 1'b0};
        tbl[1]  = '{1, 7,  24'h070000, 1'b0, 1'b1};
        tbl[2]  = '{1, 8,  24'h000100, 1'b0, 1'b0};
        tbl[3]  = '{1, 15, 24'h070100, 1'b0, 1'b1};
        tbl[4]  = '{1, 20, 24'h040200, 1'b0, 1'b0};
        tbl[5]  = '{1, 23, 24'h070200, 1'b0, 1'b1};
        tbl[6]  = '{1, 31, 24'h070300, 1'b0, 1'b1};
        tbl[7]  = '{2, 0,  24'hFFFFFF, 1'b1, 1'b0};
        tbl[8]  = '{2, 2,  24'h000000, 1'b0, 1'b0};
        tbl[9]  = '{2, 7,  24'h000000, 1'b0, 1'b1};
        tbl[10] = '{2, 8,  24'hFFFFFF, 1'b0, 1'b0};
        tbl[11] = '{2, 16, 24'h000000, 1'b0, 1'b0};
        tbl[12] = '{2, 18, 24'hFFFFFF, 1'b0, 1'b0};
        tbl[13] = '{2, 31, 24'hFFFFFF, 1'b0, 1'b1};
        tbl[14] = '{3, 1,  24'hFFFF00, 1'b0, 1'b0};
        tbl[15] = '{3, 2,  24'h00FFFF, 1'b0, 1'b0};
        tbl[16] = '{3, 6,  24'h0000FF, 1'b0, 1'b0};
        tbl[17] = '{3, 7,  24'h000000, 1'b0, 1'b1};
        tbl[18] = '{3, 8,  24'hFFFFFF, 1'b0, 1'b0};

        btbl[0]  = '{0,   24'hFFFFFF};
        btbl[1]  = '{99,  24'hFFFFFF};
        btbl[2]  = '{100, 24'hFFFF00};
        btbl[3]  = '{199, 24'hFFFF00};
        btbl[4]  = '{200, 24'h00FFFF};
        btbl[5]  = '{399, 24'h00FF00};
        btbl[6]  = '{400, 24'hFF00FF};
        btbl[7]  = '{500, 24'hFF0000};
        btbl[8]  = '{600, 24'h0000FF};
        btbl[9]  = '{700, 24'h000000};
        btbl[10] = '{799, 24'h000000};

        rst_n = 1'b0;
        nf    = 1'b0;
        mode  = 2'd0;
        color = 24'h0;
        ready = 1'b1;
        reset_cap();

        // Reset values and first-pixel latency
        repeat (3) @(negedge clk);
        chk("rst_outputs", {s_data, s_valid, s_sof, s_eol, s_done}, 32'd0);
        chk("rst_count", 32'(s_count), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_valid", 32'(s_valid), 32'd0);

        // Phase 1: gradient frame straight out of reset
        collect(45, 1'b0);
        chk("p1_pixels", 32'(cap_n), 32'd32);
        chk("p1_done_pulses", 32'(done_cnt), 32'd1);
        chk("p1_count", 32'(s_count), 32'd1);
        chk("p1_idle_valid", 32'(s_valid), 32'd0);
        sof_cnt = 0;
        for (int i = 0; i < 32; i++) if (cap_sof[i] === 1'b1) sof_cnt++;
        chk("p1_sof_total", 32'(sof_cnt), 32'd1);
        apply_table(1);

        // Phase 2: checkerboard under random stalls
        mode = 2'd2;
        reset_cap();
        pulse_next();
        collect(400, 1'b1);
        chk("p2_pixels", 32'(cap_n), 32'd32);
        chk("p2_done_pulses", 32'(done_cnt), 32'd1);
        chk("p2_count", 32'(s_count), 32'd2);
        apply_table(2);

        // Phase 3: colour bars on both instances
        mode  = 2'd1;
        ready = 1'b1;
        reset_cap();
        pulse_next();
        collect(830, 1'b0);
        chk("p3_bar_pixels", 32'(bar_n), 32'd800);
        for (int i = 0; i < 11; i++)
            chk($sformatf("bar_x%0d", btbl[i].x), 32'(bar_cap[btbl[i].x]), 32'(btbl[i].data));
        apply_table(3);

        // Phase 4: solid colour latched at the pulse, input changed mid-frame
        mode  = 2'd3;
        color = 24'h123456;
        reset_cap();
        pulse_next();
        collect(10, 1'b0);
        color = 24'hABCDEF;
        collect(40, 1'b0);
        chk("p4_pixels", 32'(cap_n), 32'd32);
        for (int i = 0; i < 32; i++)
            chk($sformatf("solid_pix%0d", i), 32'(cap_data[i]), 32'h123456);

        // Restart mid-frame while (5,1) is on the output
        mode = 2'd0;
        pulse_next();
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_valid && s_data[23:8] == 16'h0501) begin
                found = 1'b1;
                break;
            end
        end
        chk("mid_found_5_1", 32'(found), 32'd1);
        cnt0 = s_count;
        nf = 1'b1;
        @(negedge clk);
        nf = 1'b0;
        chk("mid_valid_low", 32'(s_valid), 32'd0);
        chk("mid_no_done0", 32'(s_done), 32'd0);
        @(negedge clk);
        chk("mid_restart", {s_valid, s_sof, s_data[23:8]}, {1'b1, 1'b1, 16'h0000});
        chk("mid_no_done1", 32'(s_done), 32'd0);
        chk("mid_count", 32'(s_count), 32'(cnt0));

        // Restart coinciding with acceptance of the last pixel
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (s_valid && s_eol && s_data[15:8] == 8'd3) begin
                found = 1'b1;
                break;
            end
        end
        chk("last_found", 32'(found), 32'd1);
        cnt0 = s_count;
        nf = 1'b1;
        @(negedge clk);
        nf = 1'b0;
        chk("last_no_done", 32'(s_done), 32'd0);
        chk("last_valid_low", 32'(s_valid), 32'd0);
        @(negedge clk);
        chk("last_count", 32'(s_count), 32'(cnt0));
        chk("last_restart_sof", {31'd0, s_sof}, 32'd1);

        // Asynchronous reset between edges mid-frame
        collect(5, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outputs", {s_data, s_valid, s_sof, s_eol, s_done}, 32'd0);
        chk("arst_count", 32'(s_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_release_valid", 32'(s_valid), 32'd0);
        @(negedge clk);
        chk("arst_first_pixel", {s_valid, s_sof, s_data}, {1'b1, 1'b1, 24'h000000});
        chk("arst_count_after", 32'(s_count), 32'd0);
        @(negedge clk);
        chk("arst_second_pixel", {s_valid, s_sof, s_data}, {1'b1, 1'b0, 24'h010000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/test_pattern_generator.md
# test_pattern_generator

Parametrised video test-pattern source that emits one full frame of H_ACTIVE × V_ACTIVE pixels per `in_next_frame` over a valid/ready pixel stream with start-of-frame and end-of-line markers. It feeds the scan-out path in place of the framebuffer reader for bring-up and display checks. It selects among gradient, colour-bar, checkerboard and solid-colour patterns per frame, and keeps a completed-frame count.

## Interface
- `H_ACTIVE`, 800: pixels per line (≥ 8).
- `V_ACTIVE`, 480: lines per frame (≥ 1).
- `X_WIDTH`, 10: x counter width; must satisfy 2^X_WIDTH ≥ H_ACTIVE.
- `Y_WIDTH`, 9: y counter width; must satisfy 2^Y_WIDTH ≥ V_ACTIVE.
- `COLOR_BITS`, 8: bits per channel; pixel is {R,G,B}, 3·COLOR_BITS wide.
- `CHECK_LOG2`, 5: checker square side is 2^CHECK_LOG2 pixels.

Ports:
- `in_clk`  in  1  clock; one clock domain, everything on the rising edge.
- `in_reset_n`  in  1  asynchronous active-low reset.
- `in_next_frame`  in  1  single-cycle pulse: restart at pixel (0,0) and latch the mode and colour.
- `in_mode`  in  2  0 gradient, 1 colour bars, 2 checkerboard, 3 solid.
- `in_solid_color`  in  3·COLOR_BITS  colour used in mode 3.
- `out_pixel_data`  out  3·COLOR_BITS  pixel {R,G,B}.
- `out_pixel_valid`  out  1  pixel present.
- `out_pixel_ready`  in  1  sink accepts the pixel when valid && ready.
- `out_pixel_sof`  out  1  qualifies the current pixel as (0,0).
- `out_pixel_eol`  out  1  qualifies the current pixel as x = H_ACTIVE−1.
- `out_frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- `out_frame_count`  out  16  frames completed since reset; wraps mod 2^16.

## Operation
- States are RUNNING and PAST_END. Reset enters RUNNING at (0,0) and latches `in_mode` and `in_solid_color`, the same as a reset-time `in_next_frame`.
- The output register is loaded with the pixel at (x,y) when state = RUNNING and (!valid || ready). Loading advances x. When x = H_ACTIVE−1, x wraps to 0 and y increments. Loading (H_ACTIVE−1, V_ACTIVE−1) moves the state to PAST_END.
- In PAST_END, once the final pixel is accepted, valid drops and no further pixels are generated until `in_next_frame`.
- Stream rule: while valid && !ready, data, sof and eol hold stable.
- `in_next_frame` has priority over all else, in any state and including mid-frame. It clears valid and resets the state to RUNNING at (0,0). It latches mode and colour. The pending or in-progress frame is abandoned: no frame_done, and count unchanged.
- Patterns use the frame-latched mode, with frame counter f = out_frame_count:
  - Gradient: R = x mod 2^COLOR_BITS, G = y mod 2^COLOR_BITS, B = f mod 2^COLOR_BITS.
  - Colour bars: bar b = floor(8·x / H_ACTIVE), taken from parameter-derived constant thresholds with no runtime divider. Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black. Each channel is all-ones or zero.
  - Checkerboard: white if ((x>>CHECK_LOG2) ^ (y>>CHECK_LOG2)) bit 0 = 0, else black.
  - Solid: the latched `in_solid_color`.
- Acceptance of the last pixel (valid && ready && eol && y = V_ACTIVE−1) is the frame-completion event:
  - the next cycle, out_frame_done = 1;
  - out_frame_count increments on the same edge.

## Timing
- Reset values: data = 0, valid = 0, sof = 0, eol = 0, frame_done = 0, frame_count = 0, x = 0, y = 0, state = RUNNING.
- First edge after reset release: pixel (0,0) is registered, so valid = 1 with sof = 1 from the next cycle. Latency is 1 cycle.
- The same 1-cycle latency applies after the `in_next_frame` cycle: valid is 0 in the cycle after the pulse, and (0,0) appears the cycle after that.
- Throughput is 1 pixel per cycle with ready held high. One frame takes H_ACTIVE·V_ACTIVE accepted transfers.
- `in_next_frame` coinciding with acceptance of the last pixel: the restart wins. No frame_done, and count unchanged.
- In RUNNING, valid never drops while the sink stalls.

## Test plan
- Reset, mode 0, ready = 1, H_ACTIVE=8, V_ACTIVE=2:
  - exactly 16 pixels, sof on the first, eol on pixels 8 and 16;
  - pixel 9 = {8'd0, 8'd1, 8'd0};
  - frame_done pulses once, count = 1, then valid stays 0.
- Random ready stalls at 50% in mode 2 with CHECK_LOG2=1: data, sof and eol are held across every stall. The pixel at (2,0) is black and (2,2) is white. Accepted pixels are in order with no gaps.
- Mode 1 at H_ACTIVE=800: x=0 → FFFFFF, x=99 → FFFFFF, x=100 → FFFF00, x=799 → 000000.
- Mode 3 with in_solid_color = 0x123456 at the pulse, changed to 0xABCDEF mid-frame: every pixel in the frame = 0x123456.
- `in_next_frame` pulsed mid-frame at (5,1): valid = 0 for one cycle, then (0,0) with sof = 1, no frame_done, and count unchanged.
- Async reset asserted mid-frame between clock edges: all outputs go to their reset values immediately. After release the frame restarts at (0,0) and count = 0.
